// File: rtl/alzette_seq.sv
// alzette_seq: iterative Alzette ARX-box engine.
//
// One rotate-and-combine datapath (rd = rs1 {+,-,^} ror(rs2, imm)) is reused over the
// 12 micro-operations of a full Alzette evaluation, one micro-op per RUN cycle.
//
// Ports:
//   g_clk, g_resetn        clock; synchronous active-low reset
//   in_valid / in_ready    request handshake; in_x, in_y, in_c, in_inv captured on accept
//   out_valid / out_ready  result handshake; out_x, out_y driven from the x/y registers
//   busy                   high while RUN or DONE
//
// Build option: define ALZETTE_SEQ_INV_EN to enable the inverse schedule (in_inv = 1).
// Without it, in_inv is ignored and no subtract path is built.

module alzette_seq (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic [31:0] in_c,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [1:0] {OpXor, OpAdd, OpSub} op_e;

    state_e      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] c_q, c_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;

`ifdef ALZETTE_SEQ_INV_EN
    logic        inv_q, inv_d;
`else
    logic        unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    // Rotate right by 0..31; a shift by 32 yields 0, so n = 0 returns v unchanged.
    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
        return (v >> n) | (v << (6'd32 - {1'b0, n}));
    endfunction

    // Step counter split into round (cnt / 3) and sub-op (cnt % 3).
    logic [1:0] rnd, sub;
    always_comb begin
        {rnd, sub} = 4'b0000;
        case (cnt_q)
            4'd1:    {rnd, sub} = 4'b0001;
            4'd2:    {rnd, sub} = 4'b0010;
            4'd3:    {rnd, sub} = 4'b0100;
            4'd4:    {rnd, sub} = 4'b0101;
            4'd5:    {rnd, sub} = 4'b0110;
            4'd6:    {rnd, sub} = 4'b1000;
            4'd7:    {rnd, sub} = 4'b1001;
            4'd8:    {rnd, sub} = 4'b1010;
            4'd9:    {rnd, sub} = 4'b1100;
            4'd10:   {rnd, sub} = 4'b1101;
            4'd11:   {rnd, sub} = 4'b1110;
            default: {rnd, sub} = 4'b0000;
        endcase
    end

    // Inverse walks the rounds backwards: 3 - r is the bitwise complement of a 2-bit r.
    logic [1:0] rnd_eff;
`ifdef ALZETTE_SEQ_INV_EN
    assign rnd_eff = inv_q ? ~rnd : rnd;
`else
    assign rnd_eff = rnd;
`endif

    logic [4:0] rot_a, rot_b;
    always_comb begin
        rot_a = 5'd31;
        rot_b = 5'd24;
        case (rnd_eff)
            2'd0: begin rot_a = 5'd31; rot_b = 5'd24; end
            2'd1: begin rot_a = 5'd17; rot_b = 5'd17; end
            2'd2: begin rot_a = 5'd0;  rot_b = 5'd31; end
            2'd3: begin rot_a = 5'd24; rot_b = 5'd16; end
            default: ;
        endcase
    end

    // Operand selection; the default is the "x ^= c" micro-op.
    op_e         op;
    logic [31:0] src1, opnd, rot_val, alu_res;
    logic [4:0]  amt;
    logic        dst_y;
    always_comb begin
        op    = OpXor;
        src1  = x_q;
        opnd  = c_q;
        amt   = 5'd0;
        dst_y = 1'b0;
        case (sub)
            2'd0: begin
`ifdef ALZETTE_SEQ_INV_EN
                if (!inv_q) begin
                    op   = OpAdd;
                    opnd = y_q;
                    amt  = rot_a;
                end
`else
                op   = OpAdd;
                opnd = y_q;
                amt  = rot_a;
`endif
            end
            2'd1: begin
                src1  = y_q;
                opnd  = x_q;
                amt   = rot_b;
                dst_y = 1'b1;
            end
            2'd2: begin
`ifdef ALZETTE_SEQ_INV_EN
                if (inv_q) begin
                    op   = OpSub;
                    opnd = y_q;
                    amt  = rot_a;
                end
`endif
            end
            default: ;
        endcase
    end

    assign rot_val = ror32(opnd, amt);

    always_comb begin
        alu_res = src1 ^ rot_val;
        case (op)
            OpAdd:   alu_res = src1 + rot_val;
`ifdef ALZETTE_SEQ_INV_EN
            OpSub:   alu_res = src1 - rot_val;
`endif
            default: alu_res = src1 ^ rot_val;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
`ifdef ALZETTE_SEQ_INV_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    c_d     = in_c;
`ifdef ALZETTE_SEQ_INV_EN
                    inv_d   = in_inv;
`endif
                    cnt_d   = 4'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (dst_y) begin
                    y_d = alu_res;
                end else begin
                    x_d = alu_res;
                end
                if (cnt_q == 4'd11) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered so in_ready stays low through reset and never depends on inputs.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q    <= StIdle;
            x_q        <= 32'd0;
            y_q        <= 32'd0;
            c_q        <= 32'd0;
            cnt_q      <= 4'd0;
            in_ready_q <= 1'b0;
`ifdef ALZETTE_SEQ_INV_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            c_q        <= c_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
`ifdef ALZETTE_SEQ_INV_EN
            inv_q      <= inv_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_x     = x_q;
    assign out_y     = y_q;

endmodule

// File: doc/alzette_seq.md
# alzette_seq

Iterative Alzette ARX-box engine for the Sparkle RV32 path. It time-multiplexes one combinational rotate-and-combine datapath over the 12 micro-operations of a full Alzette evaluation: `rd = rs1 {+,-,^} (rs2 >>> imm)`. A new block takes the `(x, y, c)` triple from a valid/ready producer and returns `(x', y')` to a valid/ready consumer. It sits between the ISE issue logic and the register write-back as a multi-cycle functional unit.

## Interface
Parameters: none.

Clock and reset are decided: one clock; reset is synchronous and active-low.

- `g_clk` in 1: clock; all state updates on the rising edge.
- `g_resetn` in 1: reset, synchronous, active-low.
- `in_valid` in 1: request present.
- `in_ready` out 1: engine can accept a request.
- `in_x` in 32: Alzette x input.
- `in_y` in 32: Alzette y input.
- `in_c` in 32: round constant.
- `in_inv` in 1: 1 selects inverse Alzette. Ignored unless `ALZETTE_SEQ_INV_EN` is defined.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `out_x` out 32: result x.
- `out_y` out 32: result y.
- `busy` out 1: high in RUN or DONE.

## Operation
- State machine states: IDLE, RUN, DONE.
- Internal registers: `x`, `y`, `c` (32 bits each), `inv` (1 bit), step counter `cnt` (4 bits, range 0..11).
- The round is `r = cnt / 3`. The sub-op is `s = cnt % 3`.
- Rotation pairs `(a, b)` by round:
  - round 0: (31, 24)
  - round 1: (17, 17)
  - round 2: (0, 31)
  - round 3: (24, 16)
- Forward, using round `r` in order 0..3:
  - s=0: `x <= x + ror(y, a)`
  - s=1: `y <= y ^ ror(x, b)`
  - s=2: `x <= x ^ ror(c, 0)`
- Inverse, using round `3 - r`:
  - s=0: `x <= x ^ c`
  - s=1: `y <= y ^ ror(x, b)`
  - s=2: `x <= x - ror(y, a)`
- Exactly one datapath operation is performed per RUN cycle.
- Arithmetic is modulo 2^32; carries and borrows are discarded.
- `ror` is a rotate right by 0..31.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid & in_ready`: capture `in_x`, `in_y`, `in_c`, `in_inv`; set `cnt <= 0`; go to RUN.
- RUN:
  - Execute step `cnt`.
  - If `cnt == 11`, go to DONE; otherwise `cnt <= cnt + 1`.
  - `in_valid` is ignored.
- DONE:
  - `out_valid = 1`.
  - `out_x` and `out_y` hold stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- `out_x` and `out_y` are driven directly from the `x` and `y` registers in all states. Their value is only meaningful while `out_valid` is high.
- Reset: state IDLE, `x = y = c = 0`, `cnt = 0`, `inv = 0`.
  - Outputs after reset: `out_valid = 0`, `busy = 0`, `out_x = out_y = 0`.
  - `in_ready = 0` while `g_resetn` is low, and 1 on the first cycle after release.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned with no `out_valid` pulse. The engine is in IDLE on the next cycle.
- `out_ready` high outside DONE: no effect.
- `in_valid` dropped before acceptance: nothing is captured; a request is not required to persist.

## Timing
- The accept edge is T0. RUN occupies the cycles between edges T0 and T12, with step k committed at edge T(k+1).
- `out_valid` rises in the cycle after edge T12: 12 cycles of latency from the accept edge.
- With `out_ready` tied high:
  - DONE lasts one cycle.
  - IDLE is re-entered at edge T13.
  - The next accept can occur at the earliest at edge T14.
  - Sustained throughput is one result per 14 cycles.
- Back-pressure: DONE persists indefinitely and `in_ready` stays 0 throughout.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational input-to-output path on the handshakes.

## Configuration
- `ALZETTE_SEQ_INV_EN`:
  - Defined: `in_inv` is captured at accept and selects the inverse schedule, which uses the datapath's subtract operation.
  - Undefined: `inv` is tied to 0, `in_inv` is ignored, and the subtract path and inverse rotation ordering are not instantiated. Forward timing is identical in both builds.

## Test plan
- Reset, then x=0, y=0, c=0 forward → `out_x = 0`, `out_y = 0`. `out_valid` asserts exactly 12 cycles after the accept edge. `in_ready` is 0 from T0 until IDLE is re-entered.
- x=0, y=0, c=0xB7E15162 and 1000 random (x, y, c) forward → `(out_x, out_y)` equals the golden C reference `alzette(x, y, c)`. With `out_ready` tied high, results arrive at 14-cycle spacing.
- With `ALZETTE_SEQ_INV_EN`: forward then inverse on the result, for random x/y and c=0x38B4DA56 → the original (x, y) is recovered. Without the macro, `in_inv=1` gives the same result as the forward run.
- Back-pressure: hold `out_ready = 0` for 20 cycles after `out_valid` → outputs stay stable, `in_ready = 0`, and an `in_valid` pulse is ignored. Then release `out_ready` → one transfer occurs.
- Assert `g_resetn = 0` at RUN step 5 for one cycle → no `out_valid` follows, `in_ready = 1` after release, and the next request computes correctly.
- `out_ready` held high while IDLE and RUN, then `in_valid` high for exactly one cycle → exactly one request and one result, with no spurious `out_valid`.
